// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction fetch controller. Issues one word request at a time to the
// instruction memory, captures the response together with the address it was
// fetched from into a small FIFO, and presents the FIFO head to decode through
// a valid/ready handshake. A redirect (branched_i) flushes the FIFO, loads a new
// fetch PC and, if a response is still in flight, arranges for it to be
// discarded when it returns.
//
// Optional feature: define FETCH_DEBUG_PC_EN to add a debug PC write port
// (pc_wr_debug_i / pc_debug_i) that behaves as a redirect ranked below
// branched_i. Without the macro those ports and their logic do not exist.
//
// Ports
//   clk            in   clock, all state updates on its rising edge
//   reset          in   synchronous active-high reset
//   run            in   enables issuing new memory requests
//   imem_req_o     out  memory request
//   imem_addr_o    out  memory word address (fetch PC)
//   imem_gnt_i     in   memory grant for the current request
//   imem_rvalid_i  in   memory response valid (one per grant, in order)
//   imem_rdata_i   in   memory response data
//   branched_i     in   redirect strobe
//   pc_i           in   redirect target
//   pc_wr_debug_i  in   debug PC write strobe      (FETCH_DEBUG_PC_EN only)
//   pc_debug_i     in   debug PC value             (FETCH_DEBUG_PC_EN only)
//   self_valid_o   out  buffer head valid
//   next_ready_i   in   decode ready; pops the head when valid
//   instr_o        out  head instruction (0 when empty)
//   pc_o           out  head instruction address (0 when empty)
//   success_fetch  out  one-cycle pulse for each response written to the buffer
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        branched_i,
    input  logic [31:0] pc_i,
`ifdef FETCH_DEBUG_PC_EN
    input  logic        pc_wr_debug_i,
    input  logic [31:0] pc_debug_i,
`endif
    output logic        self_valid_o,
    input  logic        next_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        success_fetch
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       fetch_pc_reg, fetch_pc_next;
    // Address of the request currently in flight; tagged onto its response.
    logic [31:0]       out_addr_reg, out_addr_next;

    logic [31:0]       buf_pc_mem    [BUF_DEPTH];
    logic [31:0]       buf_instr_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  head_reg, tail_reg;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              push;
    logic              pop;
    logic              has_space;

    // ------------------------------------------------------------------
    // Redirect sources: branched_i always wins over the debug write.
    // ------------------------------------------------------------------
`ifdef FETCH_DEBUG_PC_EN
    assign redirect    = branched_i | pc_wr_debug_i;
    assign redirect_pc = branched_i ? pc_i : pc_debug_i;
`else
    assign redirect    = branched_i;
    assign redirect_pc = pc_i;
`endif

    // A response is only kept if it belongs to a live request (WAIT) and no
    // redirect arrives in the same cycle.
    assign push = (state_reg == WAIT) && imem_rvalid_i && !redirect;
    assign pop  = self_valid_o && next_ready_i;

    // Occupancy after this cycle; a flush overrides any push/pop.
    always_comb begin
        count_next = count_reg;
        if (redirect) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Space check used when a response lands: based on the updated count,
    // since no other request is outstanding at that point.
    assign has_space = (count_next < DEPTH_C);

    // ------------------------------------------------------------------
    // FSM next state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        out_addr_next = out_addr_reg;
        imem_req_o    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // In IDLE nothing is outstanding, so the buffer count alone
                // decides whether another word fits.
                if (!redirect && run && (count_reg < DEPTH_C)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                imem_req_o = 1'b1;
                if (imem_gnt_i) begin
                    out_addr_next = fetch_pc_reg;
                    if (redirect) begin
                        // Granted request is now stale; its data must be eaten.
                        state_next = DROP;
                    end else begin
                        state_next    = WAIT;
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    if (redirect) begin
                        state_next = run ? REQ : IDLE;
                    end else begin
                        state_next = (run && has_space) ? REQ : IDLE;
                    end
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                // Buffer was flushed on entry, so there is always room here.
                if (imem_rvalid_i) begin
                    state_next = run ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (redirect) begin
            fetch_pc_next = redirect_pc;
        end
    end

    assign imem_addr_o   = fetch_pc_reg;
    assign success_fetch = push;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            out_addr_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            out_addr_reg <= out_addr_next;
        end
    end

    // ------------------------------------------------------------------
    // Instruction buffer (circular FIFO)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Storage has no reset; the outputs are gated by the valid flag instead.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_mem[tail_reg]    <= out_addr_reg;
            buf_instr_mem[tail_reg] <= imem_rdata_i;
        end
    end

    assign self_valid_o = (count_reg != '0);
    assign instr_o      = self_valid_o ? buf_instr_mem[head_reg] : 32'd0;
    assign pc_o         = self_valid_o ? buf_pc_mem[head_reg]    : 32'd0;

endmodule
